// File: rtl/i2s_adc_rx_pkg.sv
// Shared definitions for the I2S ADC capture path: state encoding, default
// geometry and the per-channel capture window helper.
package i2s_pkg;

  localparam int unsigned DEF_DATA_W   = 24;
  localparam int unsigned DEF_SLOT_W   = 32;
  localparam int unsigned DEF_BCLK_DIV = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] first;
    logic [15:0] last;
  } win_t;

  // I2S one-bit delay: a channel's MSB sits one bclk after its slot starts.
  function automatic win_t capture_window(input int unsigned slot_w,
                                          input int unsigned data_w,
                                          input logic        right);
    win_t        w;
    int unsigned base;
    base    = right ? slot_w : 0;
    w.first = 16'(base + 1);
    w.last  = 16'(base + data_w);
    return w;
  endfunction

endpackage

// File: rtl/i2s_adc_rx_sync_2ff.sv
// Two-flop single-bit synchronizer; output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S master-mode receiver: generates bclk/lrck, deserialises sdata_in into
// left/right samples and presents each pair over a valid/ready interface.
module i2s_adc_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned SLOT_W   = DEF_SLOT_W,
  parameter int unsigned BCLK_DIV = DEF_BCLK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sdata_in,
  output logic              bclk,
  output logic              lrck,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              active
);

  localparam int unsigned POS_W = $clog2(2 * SLOT_W);
  localparam int unsigned DIV_W = $clog2(BCLK_DIV);

  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(2 * SLOT_W - 1);
  localparam logic [POS_W-1:0] POS_RIGHT = POS_W'(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);

  localparam win_t L_WIN = capture_window(SLOT_W, DATA_W, 1'b0);
  localparam win_t R_WIN = capture_window(SLOT_W, DATA_W, 1'b1);

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  pos_next;
  logic              sdata_sync;
  logic [DATA_W-1:0] left_sr;
  logic [DATA_W-1:0] right_sr;
  logic              pair_done;
  logic              tick;
  logic              fall_tick;
  logic              in_left;
  logic              in_right;
  logic              pair_last;
  logic              drop;

  sync_2ff u_sync_sdata (
    .clk   (clk),
    .reset (reset),
    .d     (sdata_in),
    .q     (sdata_sync)
  );

  assign active = (state != ST_IDLE);

  always_comb begin
    tick      = active && (div_cnt == DIV_LAST);
    fall_tick = tick && bclk;
    pos_next  = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    in_left   = (16'(pos) >= L_WIN.first) && (16'(pos) <= L_WIN.last);
    in_right  = (16'(pos) >= R_WIN.first) && (16'(pos) <= R_WIN.last);
    pair_last = (16'(pos) == R_WIN.last);
    drop      = pair_done && out_valid && !out_ready;
  end

  // Divider, frame position and run/drain control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      pos     <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        div_cnt <= '0;
        pos     <= '0;
        bclk    <= 1'b0;
        lrck    <= 1'b0;
        if (enable) state <= ST_RUN;
      end else begin
        if (tick) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end

        // lrck follows the position being entered so it moves with bclk falling.
        if (fall_tick) begin
          pos  <= pos_next;
          lrck <= (pos_next >= POS_RIGHT);
        end

        if (state == ST_RUN) begin
          if (!enable) state <= ST_DRAIN;
        end else if (enable) begin
          state <= ST_RUN;
        end else if (fall_tick && (pos == POS_LAST)) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  // Capture shift registers and output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_sr    <= '0;
      right_sr   <= '0;
      pair_done  <= 1'b0;
      left_data  <= '0;
      right_data <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pair_done <= 1'b0;
      if (fall_tick) begin
        if (in_left)   left_sr   <= {left_sr[DATA_W-2:0], sdata_sync};
        if (in_right)  right_sr  <= {right_sr[DATA_W-2:0], sdata_sync};
        if (pair_last) pair_done <= 1'b1;
      end

      // An accept in the completion cycle frees the register for the new pair.
      if (pair_done && (!out_valid || out_ready)) begin
        left_data  <= left_sr;
        right_data <= right_sr;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Scoreboard bench for i2s_adc_rx: an I2S ADC model feeds directed frames,
// a monitor compares each accepted pair against the expected queue.
module tb_i2s_adc_rx;

  localparam int unsigned DW        = 24;
  localparam int unsigned SW        = 32;
  localparam int unsigned BD        = 8;
  localparam int          FRAME_CYC = 2 * SW * 2 * BD;

  logic          clk         = 1'b0;
  logic          reset       = 1'b0;
  logic          enable      = 1'b0;
  logic          sdata_in    = 1'b0;
  logic          out_ready   = 1'b0;
  logic          overrun_clr = 1'b0;
  logic          bclk;
  logic          lrck;
  logic          out_valid;
  logic          overrun;
  logic          active;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;

  i2s_adc_rx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(BD)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sdata_in    (sdata_in),
    .bclk        (bclk),
    .lrck        (lrck),
    .left_data   (left_data),
    .right_data  (right_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .active      (active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec       = 0;
  int n_err       = 0;
  int adc_cnt     = 0;
  int frames_sent = 0;
  int n_accept    = 0;
  int acc_cyc[16];

  logic [DW-1:0] adc_l_q[$];
  logic [DW-1:0] adc_r_q[$];
  logic [DW-1:0] exp_l_q[$];
  logic [DW-1:0] exp_r_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit expect_out);
    adc_l_q.push_back(l);
    adc_r_q.push_back(r);
    if (expect_out) begin
      exp_l_q.push_back(l);
      exp_r_q.push_back(r);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return bclk;
      1:       return lrck;
      2:       return out_valid;
      3:       return overrun;
      default: return active;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_level(input int w, input logic lvl, input int budget, input string name);
    int k = 0;
    @(negedge clk);
    while (sig(w) !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (sig(w) !== lvl) begin
      n_err++;
      $display("FAIL %s: level %b not reached in %0d cycles", name, lvl, budget);
    end
  endtask

  task automatic wait_rise(input int w, input int budget, input string name, output int at);
    wait_level(w, 1'b0, budget, name);
    wait_level(w, 1'b1, budget, name);
    at = cyc;
  endtask

  task automatic wait_accept(input int n, input int budget, input string name);
    int k = 0;
    @(negedge clk);
    while (n_accept < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (n_accept < n) begin
      n_err++;
      $display("FAIL %s: accepted %0d pairs, required %0d", name, n_accept, n);
    end
  endtask

  task automatic wait_pos(input int fr, input logic lr, input int c, input int budget, input string name);
    int k = 0;
    @(negedge clk);
    while (!(frames_sent == fr && lrck === lr && adc_cnt == c) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s: frame %0d slot %b bit %0d not reached", name, fr, lr, c);
    end
  endtask

  // ADC model: changes sdata_in just after each bclk falling edge.
  initial begin : adc_model
    logic [DW-1:0] cur_l;
    logic [DW-1:0] cur_r;
    logic          prev_lrck;
    cur_l     = '0;
    cur_r     = '0;
    prev_lrck = 1'b0;
    forever begin
      @(negedge bclk or negedge active);
      #1;
      if (!active) begin
        adc_cnt   = 0;
        prev_lrck = 1'b0;
        sdata_in  = 1'b0;
      end else begin
        if (lrck != prev_lrck) adc_cnt = 0;
        else adc_cnt++;
        prev_lrck = lrck;
        if (!lrck && adc_cnt == 1) begin
          if (adc_l_q.size() > 0) begin
            cur_l = adc_l_q.pop_front();
            cur_r = adc_r_q.pop_front();
          end
          frames_sent++;
        end
        if (adc_cnt >= 1 && adc_cnt <= int'(DW))
          sdata_in = lrck ? cur_r[int'(DW) - adc_cnt] : cur_l[int'(DW) - adc_cnt];
        else
          sdata_in = 1'($urandom_range(1, 0));
      end
    end
  end

  initial begin : monitor
    bit            prev_acc;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_acc) check("pulse_width", 32'(out_valid), 32'd0);
      prev_acc = 1'b0;
      if (out_valid && out_ready) begin
        prev_acc = 1'b1;
        if (exp_l_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pair: got %h/%h expected none", left_data, right_data);
        end else begin
          el = exp_l_q.pop_front();
          er = exp_r_q.pop_front();
          check("left_data", 32'(left_data), 32'(el));
          check("right_data", 32'(right_data), 32'(er));
        end
        if (n_accept < 16) acc_cyc[n_accept] = cyc;
        n_accept++;
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int t1;
    bit moved;

    // 1: reset state and idle bclk
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lrck", 32'(lrck), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_left", 32'(left_data), 32'd0);
    check("rst_right", 32'(right_data), 32'd0);
    step();
    reset = 1'b1;
    moved = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (bclk !== 1'b0 || active !== 1'b0 || out_valid !== 1'b0) moved = 1'b1;
    end
    check("idle_static", 32'(moved), 32'd0);

    // 2-4: continuous run over frames F1..F9
    frame(24'h123456, 24'hABCDEF, 1'b1);
    frame(24'h800000, 24'h7FFFFF, 1'b1);
    frame(24'h800000, 24'h7FFFFF, 1'b1);
    frame(24'h800000, 24'h7FFFFF, 1'b1);
    frame(24'h0F0F0F, 24'hF0F0F1, 1'b1);
    frame(24'h111111, 24'h222222, 1'b0);
    frame(24'h5A5A5A, 24'hA5A5A5, 1'b1);
    frame(24'h333333, 24'h444444, 1'b0);
    frame(24'h00FF00, 24'hFF00FF, 1'b1);
    step();
    out_ready = 1'b1;
    enable    = 1'b1;
    wait_rise(0, 100, "bclk_rise", t0);
    wait_rise(0, 100, "bclk_rise", t1);
    check("bclk_period", 32'(t1 - t0), 32'(2 * BD));
    wait_rise(1, 2 * FRAME_CYC, "lrck_rise", t0);
    wait_rise(1, 2 * FRAME_CYC, "lrck_rise", t1);
    check("lrck_period", 32'(t1 - t0), 32'(FRAME_CYC));

    wait_accept(4, 4 * FRAME_CYC, "accept_f4");
    check("spacing_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(FRAME_CYC));
    check("spacing_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(FRAME_CYC));
    check("spacing_23", 32'(acc_cyc[3] - acc_cyc[2]), 32'(FRAME_CYC));

    step();
    out_ready = 1'b0;
    wait_level(3, 1'b1, 3 * FRAME_CYC, "overrun_set");
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_left", 32'(left_data), 32'h0F0F0F);
    check("hold_right", 32'(right_data), 32'hF0F0F1);
    step();
    out_ready = 1'b1;
    wait_accept(5, 10, "accept_a");
    step();
    out_ready   = 1'b0;
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    @(negedge clk);
    check("overrun_clr", 32'(overrun), 32'd0);

    wait_level(2, 1'b1, 2 * FRAME_CYC, "f7_valid");
    step();
    overrun_clr = 1'b1;
    wait_level(3, 1'b1, 2 * FRAME_CYC, "overrun_set_over_clr");
    check("hold_left_f7", 32'(left_data), 32'h5A5A5A);
    @(negedge clk);
    check("overrun_clr_after", 32'(overrun), 32'd0);
    step();
    overrun_clr = 1'b0;
    out_ready   = 1'b1;
    wait_accept(6, 10, "accept_f7");

    // 5: enable dropped at pos 10 of F9
    wait_pos(9, 1'b0, 10, 2 * FRAME_CYC, "pos10");
    step();
    enable = 1'b0;
    wait_accept(7, FRAME_CYC, "accept_f9");
    wait_level(4, 1'b0, FRAME_CYC, "drain_to_idle");
    check("idle_bclk", 32'(bclk), 32'd0);
    check("idle_lrck", 32'(lrck), 32'd0);
    moved = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (bclk !== 1'b0 || active !== 1'b0) moved = 1'b1;
    end
    check("idle_after_drain", 32'(moved), 32'd0);

    // 6: reset mid right slot, then a fresh frame
    frame(24'h777777, 24'h888888, 1'b0);
    step();
    enable = 1'b1;
    wait_pos(10, 1'b1, 5, 2 * FRAME_CYC, "pos_s5");
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_bclk", 32'(bclk), 32'd0);
    check("mid_rst_lrck", 32'(lrck), 32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_left", 32'(left_data), 32'd0);
    check("mid_rst_right", 32'(right_data), 32'd0);
    frame(24'h654321, 24'hFEDCBA, 1'b1);
    repeat (5) step();
    reset = 1'b1;
    wait_accept(8, 2 * FRAME_CYC, "accept_f11");
    step();
    enable = 1'b0;
    wait_level(4, 1'b0, 2 * FRAME_CYC, "final_idle");
    repeat (20) @(negedge clk);
    check("exp_queue_empty", 32'(exp_l_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
